// File: rtl/div_issue_ctrl.sv
// EX-stage sequencer for MIPS DIV/DIVU: latches operands, runs the divider
// start/annul handshake, stalls EX while busy and issues one HI/LO write.
module div_issue_ctrl #(
    parameter int unsigned DW            = 32,
    parameter int unsigned CANCEL_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_div_valid_i,
    input  logic          ex_div_signed_i,
    input  logic [DW-1:0] ex_op1_i,
    input  logic [DW-1:0] ex_op2_i,
    input  logic          flush_i,
    input  logic [2*DW-1:0] div_result_i,
    input  logic          div_ready_i,
    output logic          div_start_o,
    output logic          div_annul_o,
    output logic          div_signed_o,
    output logic [DW-1:0] div_op1_o,
    output logic [DW-1:0] div_op2_o,
    output logic          stallreq_o,
    output logic          hilo_we_o,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    localparam int unsigned CW = (CANCEL_CYCLES < 2) ? 1 : $clog2(CANCEL_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        CANCEL
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            start_q;
    logic            annul_q;
    logic            signed_q;
    logic [DW-1:0]   op1_q;
    logic [DW-1:0]   op2_q;
    logic [DW-1:0]   hi_q;
    logic [DW-1:0]   lo_q;
    logic            issue;

    assign issue = ex_div_valid_i & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            annul_q  <= 1'b0;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        op1_q    <= ex_op1_i;
                        op2_q    <= ex_op2_i;
                        signed_q <= ex_div_signed_i;
                        start_q  <= 1'b1;
                        state_q  <= BUSY;
                    end
                end
                // Operands and signed flag stay frozen: the divider re-reads
                // them at completion for sign correction.
                BUSY: begin
                    if (flush_i) begin
                        start_q <= 1'b0;
                        annul_q <= 1'b1;
                        cnt_q   <= CW'(CANCEL_CYCLES);
                        state_q <= CANCEL;
                    end else if (div_ready_i) begin
                        hi_q    <= div_result_i[2*DW-1:DW];
                        lo_q    <= div_result_i[DW-1:0];
                        start_q <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                CANCEL: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        annul_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stallreq_o   = (state_q == BUSY) | ((state_q == IDLE) & issue);
    assign hilo_we_o    = (state_q == DONE) & ~flush_i;
    assign div_start_o  = start_q;
    assign div_annul_o  = annul_q;
    assign div_signed_o = signed_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl; the divider is modelled in the bench
// and fed from the DUT's latched operands.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_div_valid_i;
    logic        ex_div_signed_i;
    logic [31:0] ex_op1_i;
    logic [31:0] ex_op2_i;
    logic        flush_i;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        stallreq_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.DW(32), .CANCEL_CYCLES(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_div_valid_i  (ex_div_valid_i),
        .ex_div_signed_i (ex_div_signed_i),
        .ex_op1_i        (ex_op1_i),
        .ex_op2_i        (ex_op2_i),
        .flush_i         (flush_i),
        .div_result_i    (div_result_i),
        .div_ready_i     (div_ready_i),
        .div_start_o     (div_start_o),
        .div_annul_o     (div_annul_o),
        .div_signed_o    (div_signed_o),
        .div_op1_o       (div_op1_o),
        .div_op2_o       (div_op2_o),
        .stallreq_o      (stallreq_o),
        .hilo_we_o       (hilo_we_o),
        .hi_o            (hi_o),
        .lo_o            (lo_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Divider behaviour: {remainder, quotient}, x/0 -> 0/0, remainder takes dividend sign.
    function automatic logic [63:0] divmodel(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic busy_checks(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        chk({tag, "_busy_start"}, div_start_o, 1'b1);
        chk({tag, "_busy_stall"}, stallreq_o, 1'b1);
        chk({tag, "_busy_we"}, hilo_we_o, 1'b0);
        chk({tag, "_busy_op1"}, div_op1_o, a);
        chk({tag, "_busy_op2"}, div_op2_o, b);
        chk({tag, "_busy_signed"}, div_signed_o, s);
    endtask

    task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input int busy, input logic [31:0] eh, input logic [31:0] el);
        ex_div_valid_i  = 1'b1;
        ex_div_signed_i = s;
        ex_op1_i        = a;
        ex_op2_i        = b;
        #1;
        chk({tag, "_issue_stall"}, stallreq_o, 1'b1);
        chk({tag, "_issue_start"}, div_start_o, 1'b0);
        step();
        for (int i = 0; i < busy; i++) begin
            busy_checks(tag, s, a, b);
            ex_op1_i        = ~a;
            ex_op2_i        = ~b;
            ex_div_signed_i = ~s;
            if (i == busy - 1) begin
                div_ready_i  = 1'b1;
                div_result_i = divmodel(div_signed_o, div_op1_o, div_op2_o);
            end
            step();
        end
        div_ready_i  = 1'b0;
        div_result_i = '0;
        #1;
        chk({tag, "_done_we"}, hilo_we_o, 1'b1);
        chk({tag, "_done_hi"}, hi_o, eh);
        chk({tag, "_done_lo"}, lo_o, el);
        chk({tag, "_done_stall"}, stallreq_o, 1'b0);
        chk({tag, "_done_start"}, div_start_o, 1'b0);
        ex_div_valid_i = 1'b0;
        step();
        chk({tag, "_idle_we"}, hilo_we_o, 1'b0);
        chk({tag, "_idle_start"}, div_start_o, 1'b0);
        chk({tag, "_idle_hi"}, hi_o, eh);
        chk({tag, "_idle_lo"}, lo_o, el);
    endtask

    task automatic cancel_checks(input string tag, input logic [31:0] eh, input logic [31:0] el);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_cancel_annul"}, div_annul_o, 1'b1);
            chk({tag, "_cancel_start"}, div_start_o, 1'b0);
            chk({tag, "_cancel_stall"}, stallreq_o, 1'b0);
            chk({tag, "_cancel_we"}, hilo_we_o, 1'b0);
            chk({tag, "_cancel_hi"}, hi_o, eh);
            chk({tag, "_cancel_lo"}, lo_o, el);
            step();
        end
        chk({tag, "_after_annul"}, div_annul_o, 1'b0);
        chk({tag, "_after_start"}, div_start_o, 1'b0);
    endtask

    initial begin
        rst_n           = 1'b1;
        ex_div_valid_i  = 1'b0;
        ex_div_signed_i = 1'b0;
        ex_op1_i        = '0;
        ex_op2_i        = '0;
        flush_i         = 1'b0;
        div_result_i    = '0;
        div_ready_i     = 1'b0;
        #2 rst_n = 1'b0;
        step(); step(); step();
        chk("rst_start", div_start_o, 1'b0);
        chk("rst_annul", div_annul_o, 1'b0);
        chk("rst_signed", div_signed_o, 1'b0);
        chk("rst_ops", {div_op1_o, div_op2_o}, 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_we", hilo_we_o, 1'b0);
        chk("rst_stall", stallreq_o, 1'b0);
        rst_n = 1'b1;
        step();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 36, 32'd2, 32'd14);
        run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 5, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

        // Flush 10 cycles into BUSY; a new DIVU 9/2 waits in EX during CANCEL.
        ex_div_valid_i = 1'b1; ex_div_signed_i = 1'b0; ex_op1_i = 32'd100; ex_op2_i = 32'd3;
        step();
        for (int i = 0; i < 10; i++) begin
            busy_checks("flush10", 1'b0, 32'd100, 32'd3);
            step();
        end
        flush_i = 1'b1;
        #1;
        chk("flush10_flush_stall", stallreq_o, 1'b1);
        ex_op1_i = 32'd9; ex_op2_i = 32'd2;
        step();
        flush_i = 1'b0;
        #1;
        cancel_checks("flush10", 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        run_div("divu_9_2", 1'b0, 32'd9, 32'd2, 4, 32'd1, 32'd4);

        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 3, 32'd0, 32'd0);

        // Flush coincident with div_ready_i: flush wins, result discarded.
        ex_div_valid_i = 1'b1; ex_div_signed_i = 1'b0; ex_op1_i = 32'd100; ex_op2_i = 32'd7;
        step();
        busy_checks("flushrdy", 1'b0, 32'd100, 32'd7);
        step();
        flush_i      = 1'b1;
        div_ready_i  = 1'b1;
        div_result_i = divmodel(div_signed_o, div_op1_o, div_op2_o);
        step();
        flush_i = 1'b0; div_ready_i = 1'b0; div_result_i = '0; ex_div_valid_i = 1'b0;
        #1;
        cancel_checks("flushrdy", 32'd0, 32'd0);

        // Flush during DONE suppresses the write.
        ex_div_valid_i = 1'b1; ex_div_signed_i = 1'b0; ex_op1_i = 32'd6; ex_op2_i = 32'd3;
        step();
        busy_checks("flushdone", 1'b0, 32'd6, 32'd3);
        div_ready_i  = 1'b1;
        div_result_i = divmodel(div_signed_o, div_op1_o, div_op2_o);
        step();
        div_ready_i = 1'b0; div_result_i = '0; flush_i = 1'b1;
        #1;
        chk("flushdone_we", hilo_we_o, 1'b0);
        chk("flushdone_stall", stallreq_o, 1'b0);
        ex_div_valid_i = 1'b0;
        step();
        flush_i = 1'b0;
        #1;
        chk("flushdone_idle_we", hilo_we_o, 1'b0);
        chk("flushdone_idle_annul", div_annul_o, 1'b0);
        chk("flushdone_idle_stall", stallreq_o, 1'b0);

        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4, 32'd0, 32'h8000_0000);
        run_div("divu_6_3", 1'b0, 32'd6, 32'd3, 4, 32'd0, 32'd2);

        // Reset in the middle of a third divide.
        ex_div_valid_i = 1'b1; ex_div_signed_i = 1'b1; ex_op1_i = 32'd50; ex_op2_i = 32'd5;
        step();
        busy_checks("rstmid", 1'b1, 32'd50, 32'd5);
        step();
        ex_div_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid_start", div_start_o, 1'b0);
        chk("rstmid_signed", div_signed_o, 1'b0);
        chk("rstmid_ops", {div_op1_o, div_op2_o}, 64'd0);
        chk("rstmid_hilo", {hi_o, lo_o}, 64'd0);
        chk("rstmid_stall", stallreq_o, 1'b0);
        step();
        chk("rstmid_we", hilo_we_o, 1'b0);
        rst_n = 1'b1;
        step();
        chk("rstmid_post_we", hilo_we_o, 1'b0);
        chk("rstmid_post_start", div_start_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- EX-stage sequencer for MIPS DIV/DIVU; sits between the EX decode/ALU datapath and the multi-cycle divider.
- Latches the operands and runs the divider start/annul handshake.
- Stalls the pipeline while the divide is in flight, then delivers a single HI/LO write pulse.
- Handles pipeline flushes (exception or branch cancel) by annulling the divider and discarding the result.

Parameters:
- DW, 32, operand width (divider result width is 2*DW).
- CANCEL_CYCLES, 3, cycles that annul is held high with start low after a flush, before returning to IDLE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_div_valid_i  in  1  a DIV/DIVU instruction is present in EX.
- ex_div_signed_i  in  1  1 = DIV, 0 = DIVU.
- ex_op1_i  in  DW  dividend (rs).
- ex_op2_i  in  DW  divisor (rt).
- flush_i  in  1  kill the EX instruction this cycle.
- div_result_i  in  2*DW  divider result; {remainder, quotient}.
- div_ready_i  in  1  divider result-ready flag.
- div_start_o  out  1  divider start, registered.
- div_annul_o  out  1  divider cancel, registered.
- div_signed_o  out  1  registered signed flag to the divider.
- div_op1_o  out  DW  registered dividend to the divider.
- div_op2_o  out  DW  registered divisor to the divider.
- stallreq_o  out  1  combinational pipeline stall request.
- hilo_we_o  out  1  HI/LO write enable.
- hi_o  out  DW  remainder to HI.
- lo_o  out  DW  quotient to LO.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All registered outputs and the cancel counter clear to 0.
  - Reset mid-operation abandons the divide; no write occurs.
- States: IDLE, BUSY, DONE, CANCEL.
- IDLE:
  - Issue = ex_div_valid_i & ~flush_i.
  - On issue: latch ex_op1_i, ex_op2_i and ex_div_signed_i into div_op1_o, div_op2_o and div_signed_o; set div_start_o=1; go to BUSY.
  - stallreq_o = issue.
- BUSY:
  - div_start_o, the operands and div_signed_o are held stable. The divider re-reads the operands and the signed flag at completion for sign correction, so they must not change.
  - stallreq_o = 1.
  - flush_i=1: div_start_o←0, div_annul_o←1, load the cancel counter with CANCEL_CYCLES, go to CANCEL. Flush has priority over a simultaneous div_ready_i.
  - Else div_ready_i=1: capture hi_o←div_result_i[2*DW-1:DW] and lo_o←div_result_i[DW-1:0]; div_start_o←0; go to DONE.
- DONE (exactly 1 cycle):
  - hilo_we_o = ~flush_i (combinational gate on the DONE state).
  - stallreq_o = 0, so the instruction leaves EX this cycle.
  - div_start_o stays low, which returns the divider to its free state by the next edge.
  - Next state is IDLE.
- CANCEL:
  - div_start_o=0, div_annul_o=1, stallreq_o=0.
  - The counter decrements each cycle; at 1 it clears div_annul_o and the next state is IDLE.
  - ex_div_valid_i is ignored while in CANCEL; the next issue is taken in IDLE.
- hi_o and lo_o keep their last captured value when not writing. hilo_we_o is 1 only in DONE.
- Divide-by-zero needs no special handling: the divider returns 0/0 after a short fixed latency, and the sequence BUSY→DONE writes HI=LO=0.
- Back-to-back DIVs: DONE→IDLE guarantees at least one cycle with div_start_o=0 between divides. The second div stalls from its IDLE issue cycle.
- Latency for a nonzero divisor: hilo_we_o asserts 35–40 cycles after the issue cycle. The bench checks against div_ready_i, not a fixed count.

Test Plan:
- DIVU 100/7: issue → stallreq_o held high until DONE → one-cycle hilo_we_o with hi_o=2, lo_o=14; div_start_o low in DONE.
- DIV 0xFFFFFF9C (−100) / 7 → hi_o=0xFFFFFFFE, lo_o=0xFFFFFFF2; div_op1_o/div_op2_o/div_signed_o constant for the whole of BUSY.
- DIVU 5/0 → hi_o=lo_o=0, hilo_we_o pulses within 6 cycles of issue, stall released in DONE.
- Flush 10 cycles into BUSY → div_annul_o high for 3 cycles with start low; no hilo_we_o; a following DIVU 9/2 gives hi_o=1, lo_o=4.
- Flush coincident with div_ready_i, and separately flush during DONE → no hilo_we_o; state returns to IDLE.
- Two consecutive DIVs (0x80000000/−1 signed, then 6/3) → two separate write pulses with correct results; rst_n pulsed mid-BUSY of a third div → all outputs 0, no write.
